// File: rtl/uart_apb_pkg.sv
// Shared definitions for the UART APB initiator: FSM encoding, default bus sizing
// and the wait-counter width helper.
package uart_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam int DEF_AWIDTH  = 8;
  localparam int DEF_DWIDTH  = 32;
  localparam int DEF_TIMEOUT = 16;

  // A disabled timeout (0) still needs a 1-bit counter register.
  function automatic int timeout_cnt_w(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/uart_apb_master_if.sv
// Command, response and APB request/completion signals of the UART APB initiator.
interface uart_apb_master_if
  import uart_apb_pkg::*;
#(
  parameter int AWIDTH = DEF_AWIDTH,
  parameter int DWIDTH = DEF_DWIDTH
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_wr_i;
  logic [AWIDTH-1:0]     cmd_addr_i;
  logic [DWIDTH-1:0]     cmd_wdata_i;
  logic [DWIDTH/8-1:0]   cmd_strb_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DWIDTH-1:0]     rsp_rdata_o;
  logic                  rsp_err_o;
  logic                  rsp_timeout_o;

  logic [AWIDTH-1:0]     apb_addr_o;
  logic                  apb_wr_o;
  logic [DWIDTH-1:0]     apb_wdata_o;
  logic [DWIDTH/8-1:0]   apb_strb_o;
  logic                  apb_sel_o;
  logic                  apb_en_o;
  logic [DWIDTH-1:0]     apb_rdata_i;
  logic                  apb_ready_i;
  logic                  apb_err_i;

  modport master (
    input  cmd_valid_i, cmd_wr_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    input  rsp_ready_i,
    output apb_addr_o, apb_wr_o, apb_wdata_o, apb_strb_o, apb_sel_o, apb_en_o,
    input  apb_rdata_i, apb_ready_i, apb_err_i
  );

  modport slave (
    output cmd_valid_i, cmd_wr_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    output rsp_ready_i,
    input  apb_addr_o, apb_wr_o, apb_wdata_o, apb_strb_o, apb_sel_o, apb_en_o,
    output apb_rdata_i, apb_ready_i, apb_err_i
  );

endinterface

// File: rtl/uart_apb_master.sv
// Single-beat APB initiator: one command in, one SETUP/ACCESS transfer out, one
// response back carrying read data, slave error and a local timeout flag.
module uart_apb_master
  import uart_apb_pkg::*;
#(
  parameter int AWIDTH  = DEF_AWIDTH,
  parameter int DWIDTH  = DEF_DWIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_apb_master_if.master bus
);

  localparam int SW = DWIDTH / 8;
  localparam int CW = timeout_cnt_w(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  apb_state_e        state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              wr_q, wr_nxt;
  logic [AWIDTH-1:0] addr_q, addr_nxt;
  logic [DWIDTH-1:0] wdata_q, wdata_nxt;
  logic [SW-1:0]     strb_q, strb_nxt;
  logic [DWIDTH-1:0] rdata_q, rdata_nxt;
  logic              err_q, err_nxt;
  logic              to_q, to_nxt;

  // The wait counter sticks at all-ones so a disabled timeout can never wrap into a match.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_nxt    = wr_q;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    strb_nxt  = strb_q;
    rdata_nxt = rdata_q;
    err_nxt   = err_q;
    to_nxt    = to_q;
    case (state)
      IDLE: begin
        if (bus.cmd_valid_i) begin
          wr_nxt    = bus.cmd_wr_i;
          addr_nxt  = bus.cmd_addr_i;
          wdata_nxt = bus.cmd_wdata_i;
          strb_nxt  = bus.cmd_wr_i ? bus.cmd_strb_i : '0;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        cnt_nxt   = '0;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        if (bus.apb_ready_i) begin
          rdata_nxt = wr_q ? '0 : bus.apb_rdata_i;
          err_nxt   = bus.apb_err_i;
          to_nxt    = 1'b0;
          state_nxt = RESP;
        end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
          // Slave abandoned: report locally, dropping sel/en without its completion.
          rdata_nxt = '0;
          err_nxt   = 1'b1;
          to_nxt    = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      wr_q    <= wr_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      strb_q  <= strb_nxt;
      rdata_q <= rdata_nxt;
      err_q   <= err_nxt;
      to_q    <= to_nxt;
    end
  end

  // rst_n gates ready so no command looks accepted while reset is held.
  assign bus.cmd_ready_o   = rst_n && (state == IDLE);
  assign bus.rsp_valid_o   = (state == RESP);
  assign bus.rsp_rdata_o   = rdata_q;
  assign bus.rsp_err_o     = err_q;
  assign bus.rsp_timeout_o = to_q;

  assign bus.apb_sel_o   = (state == SETUP) || (state == ACCESS);
  assign bus.apb_en_o    = (state == ACCESS);
  assign bus.apb_addr_o  = addr_q;
  assign bus.apb_wr_o    = wr_q;
  assign bus.apb_wdata_o = wdata_q;
  assign bus.apb_strb_o  = strb_q;

endmodule

// File: tb/tb_uart_apb_master.sv
// Directed bench for uart_apb_master: a TIMEOUT=16 instance for the main sequence and
// a TIMEOUT=0 instance for the unbounded-wait case.
module tb_uart_apb_master;

  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  uart_apb_master_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();
  uart_apb_master_if #(.AWIDTH(AW), .DWIDTH(DW)) bus0 ();

  uart_apb_master #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  uart_apb_master #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present a command while idle and let it be accepted on the next edge.
  task automatic issue(input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [DW/8-1:0] strb);
    bus.cmd_wr_i    = wr;
    bus.cmd_addr_i  = addr;
    bus.cmd_wdata_i = wdata;
    bus.cmd_strb_i  = strb;
    bus.cmd_valid_i = 1'b1;
    chk("issue_cmd_ready", bus.cmd_ready_o, 1);
    step();
    bus.cmd_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t_idle;
    int t0, t1, t2;
    int acc;

    bus.cmd_valid_i = 0; bus.cmd_wr_i = 0; bus.cmd_addr_i = '0;
    bus.cmd_wdata_i = '0; bus.cmd_strb_i = '0; bus.rsp_ready_i = 0;
    bus.apb_rdata_i = '0; bus.apb_ready_i = 0; bus.apb_err_i = 0;
    bus0.cmd_valid_i = 0; bus0.cmd_wr_i = 0; bus0.cmd_addr_i = '0;
    bus0.cmd_wdata_i = '0; bus0.cmd_strb_i = '0; bus0.rsp_ready_i = 0;
    bus0.apb_rdata_i = '0; bus0.apb_ready_i = 0; bus0.apb_err_i = 0;

    // Reset values
    step(); step();
    chk("rst_cmd_ready", bus.cmd_ready_o, 0);
    chk("rst_sel", bus.apb_sel_o, 0);
    chk("rst_en", bus.apb_en_o, 0);
    chk("rst_rsp_valid", bus.rsp_valid_o, 0);
    chk("rst_rsp_err", bus.rsp_err_o, 0);
    chk("rst_rsp_timeout", bus.rsp_timeout_o, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata_o, 0);
    chk("rst_apb_addr", bus.apb_addr_o, 0);
    chk("rst_apb_wr", bus.apb_wr_o, 0);
    chk("rst_apb_wdata", bus.apb_wdata_o, 0);
    chk("rst_apb_strb", bus.apb_strb_o, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_cmd_ready", bus.cmd_ready_o, 1);
    chk("post_rst_cmd_ready0", bus0.cmd_ready_o, 1);

    // Write, zero-wait slave; rdata on the bus must not leak into a write response
    bus.apb_ready_i = 1; bus.apb_err_i = 0; bus.apb_rdata_i = 32'hDEAD_BEEF;
    issue(1'b1, 8'h04, 32'hA5A5_0001, 4'hF);
    chk("wr_setup_sel", bus.apb_sel_o, 1);
    chk("wr_setup_en", bus.apb_en_o, 0);
    chk("wr_setup_pwrite", bus.apb_wr_o, 1);
    chk("wr_setup_addr", bus.apb_addr_o, 8'h04);
    chk("wr_setup_wdata", bus.apb_wdata_o, 32'hA5A5_0001);
    chk("wr_setup_strb", bus.apb_strb_o, 4'hF);
    chk("wr_setup_cmd_ready", bus.cmd_ready_o, 0);
    step();
    chk("wr_access_sel", bus.apb_sel_o, 1);
    chk("wr_access_en", bus.apb_en_o, 1);
    chk("wr_access_rsp_valid", bus.rsp_valid_o, 0);
    step();
    chk("wr_rsp_valid", bus.rsp_valid_o, 1);
    chk("wr_rsp_err", bus.rsp_err_o, 0);
    chk("wr_rsp_timeout", bus.rsp_timeout_o, 0);
    chk("wr_rsp_rdata", bus.rsp_rdata_o, 0);
    chk("wr_rsp_sel", bus.apb_sel_o, 0);
    chk("wr_rsp_en", bus.apb_en_o, 0);
    bus.rsp_ready_i = 1;
    step();
    chk("wr_idle_rsp_valid", bus.rsp_valid_o, 0);
    chk("wr_idle_cmd_ready", bus.cmd_ready_o, 1);
    chk("wr_idle_addr_hold", bus.apb_addr_o, 8'h04);

    // Read with two wait states; strobes forced to zero
    bus.apb_ready_i = 0; bus.apb_rdata_i = 32'h0;
    issue(1'b0, 8'h08, 32'hFFFF_FFFF, 4'hF);
    chk("rd_setup_strb", bus.apb_strb_o, 0);
    chk("rd_setup_pwrite", bus.apb_wr_o, 0);
    chk("rd_setup_addr", bus.apb_addr_o, 8'h08);
    step();
    chk("rd_access1_en", bus.apb_en_o, 1);
    step();
    chk("rd_access2_en", bus.apb_en_o, 1);
    step();
    chk("rd_access3_rsp_valid", bus.rsp_valid_o, 0);
    bus.apb_ready_i = 1; bus.apb_rdata_i = 32'h0000_00C3;
    step();
    chk("rd_rsp_valid", bus.rsp_valid_o, 1);
    chk("rd_rsp_rdata", bus.rsp_rdata_o, 32'h0000_00C3);
    chk("rd_rsp_err", bus.rsp_err_o, 0);
    bus.apb_rdata_i = 32'h0;
    step();
    chk("rd_idle_next_cmd_ready", bus.cmd_ready_o, 1);
    chk("rd_idle_rsp_valid", bus.rsp_valid_o, 0);

    // Write with slave error, response held off for 5 cycles with a command waiting
    bus.rsp_ready_i = 0; bus.apb_ready_i = 1; bus.apb_err_i = 1;
    issue(1'b1, 8'h0C, 32'h1234_5678, 4'h3);
    step(); step();
    chk("err_rsp_valid", bus.rsp_valid_o, 1);
    chk("err_rsp_err", bus.rsp_err_o, 1);
    chk("err_rsp_timeout", bus.rsp_timeout_o, 0);
    bus.apb_err_i = 0; bus.apb_rdata_i = 32'h0000_0011;
    bus.cmd_wr_i = 0; bus.cmd_addr_i = 8'h10; bus.cmd_valid_i = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_rsp_valid", bus.rsp_valid_o, 1);
      chk("hold_rsp_err", bus.rsp_err_o, 1);
      chk("hold_cmd_ready", bus.cmd_ready_o, 0);
      chk("hold_sel", bus.apb_sel_o, 0);
    end
    bus.rsp_ready_i = 1;
    step();
    chk("hold_release_cmd_ready", bus.cmd_ready_o, 1);
    t_idle = cyc;

    // Back-to-back reads: one response every 4 cycles
    n = 0;
    while (bus.rsp_valid_o !== 1'b1 && n < 50) begin step(); n++; end
    chk("tp_rsp0_seen", bus.rsp_valid_o, 1);
    chk("tp_rsp0_rdata", bus.rsp_rdata_o, 32'h0000_0011);
    t0 = cyc;
    chk("tp_first_latency", t0 - t_idle, 3);
    step();
    n = 0;
    while (bus.rsp_valid_o !== 1'b1 && n < 50) begin step(); n++; end
    chk("tp_rsp1_seen", bus.rsp_valid_o, 1);
    t1 = cyc;
    step();
    n = 0;
    while (bus.rsp_valid_o !== 1'b1 && n < 50) begin step(); n++; end
    chk("tp_rsp2_seen", bus.rsp_valid_o, 1);
    t2 = cyc;
    bus.cmd_valid_i = 0;
    chk("tp_spacing_01", t1 - t0, 4);
    chk("tp_spacing_12", t2 - t1, 4);
    step();
    chk("tp_end_idle", bus.cmd_ready_o, 1);

    // Timeout on a read: 16 ACCESS cycles, then local error
    bus.apb_ready_i = 0; bus.apb_rdata_i = 32'hDEAD_BEEF;
    issue(1'b0, 8'h14, 32'h0, 4'h0);
    step();
    acc = 0;
    while (bus.apb_en_o === 1'b1 && acc < 100) begin acc++; step(); end
    chk("to_access_cycles", acc, 16);
    chk("to_rsp_valid", bus.rsp_valid_o, 1);
    chk("to_rsp_err", bus.rsp_err_o, 1);
    chk("to_rsp_timeout", bus.rsp_timeout_o, 1);
    chk("to_rsp_rdata", bus.rsp_rdata_o, 0);
    chk("to_sel_dropped", bus.apb_sel_o, 0);
    step();
    chk("to_idle_cmd_ready", bus.cmd_ready_o, 1);

    // TIMEOUT=0 instance waits as long as the slave stalls
    bus0.cmd_wr_i = 1; bus0.cmd_addr_i = 8'h20; bus0.cmd_wdata_i = 32'h5A;
    bus0.cmd_strb_i = 4'h1; bus0.cmd_valid_i = 1;
    step();
    bus0.cmd_valid_i = 0;
    repeat (41) step();
    chk("nto_still_en", bus0.apb_en_o, 1);
    chk("nto_no_rsp", bus0.rsp_valid_o, 0);
    bus0.apb_ready_i = 1;
    step();
    chk("nto_rsp_valid", bus0.rsp_valid_o, 1);
    chk("nto_rsp_timeout", bus0.rsp_timeout_o, 0);
    chk("nto_rsp_err", bus0.rsp_err_o, 0);
    bus0.rsp_ready_i = 1;
    step();
    chk("nto_idle_cmd_ready", bus0.cmd_ready_o, 1);

    // Reset while in ACCESS drops the command with no response
    bus.apb_ready_i = 0;
    issue(1'b1, 8'h18, 32'hCAFE_0000, 4'hF);
    step();
    chk("mrst_in_access", bus.apb_en_o, 1);
    rst_n = 1'b0;
    step();
    chk("mrst_sel", bus.apb_sel_o, 0);
    chk("mrst_en", bus.apb_en_o, 0);
    chk("mrst_rsp_valid", bus.rsp_valid_o, 0);
    chk("mrst_cmd_ready", bus.cmd_ready_o, 0);
    chk("mrst_addr", bus.apb_addr_o, 0);
    rst_n = 1'b1;
    bus.apb_ready_i = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("mrst_no_rsp", bus.rsp_valid_o, 0);
      chk("mrst_idle_sel", bus.apb_sel_o, 0);
    end
    chk("mrst_idle_cmd_ready", bus.cmd_ready_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
